// File: rtl/spread.sv
// DSSS spreader: one data bit in per handshake, SPREAD chips out (bit XOR code chip).
// Back-to-back bits stream without a gap. The code is applied MSB first.
module spread #(
    parameter int unsigned          SPREAD = 24,
    parameter logic [SPREAD-1:0]    CODE   = 24'hB53CE1
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_readi,
    input  logic i_data,
    input  logic i_valid,
    output logic o_data,
    output logic o_valid
);

    localparam int unsigned         CNT_W = (SPREAD > 1) ? $clog2(SPREAD) : 1;
    localparam logic [CNT_W-1:0]    LAST  = CNT_W'(SPREAD - 1);

    typedef enum logic [1:0] {
        RST_WAIT,
        IDLE,
        SPREADING
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             bit_q;
    logic             bit_n;
    logic             valid_n;
    logic             data_n;
    logic             ready_st;

    // Code chip for counter value k; chip 0 is the code MSB.
    function automatic logic chip_at(input logic [CNT_W-1:0] k);
        logic [CNT_W-1:0] idx;
        idx = LAST - k;
        return CODE[idx];
    endfunction

    // Ready depends on state/counter only; reset holds it low for every reset cycle.
    always_comb begin
        ready_st = (state == IDLE) || ((state == SPREADING) && (cnt == LAST));
        o_readi  = ready_st && !i_reset;
    end

    // Next-state, counter, latched bit and next registered outputs.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_q;
        case (state)
            RST_WAIT: begin
                state_n = IDLE;
            end
            IDLE: begin
                if (i_valid) begin
                    bit_n   = i_data;
                    cnt_n   = '0;
                    state_n = SPREADING;
                end
            end
            SPREADING: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (i_valid) begin
                        bit_n = i_data;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = RST_WAIT;
                cnt_n   = '0;
            end
        endcase
        valid_n = (state_n == SPREADING);
        data_n  = valid_n && (bit_n ^ chip_at(cnt_n));
    end

    // State and output registers; reset aborts any bit in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= RST_WAIT;
            cnt     <= '0;
            bit_q   <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_q   <= bit_n;
            o_valid <= valid_n;
            o_data  <= data_n;
        end
    end

endmodule

// File: tb/tb_spread.sv
// Directed bench for spread: chip scoreboard filled on acceptance, drained per output cycle.
module tb_spread;

    logic i_clk = 1'b0;
    logic i_reset;
    logic o_readi;
    logic i_data;
    logic i_valid;
    logic o_data;
    logic o_valid;

    int   checks   = 0;
    int   errors   = 0;
    int   run_len  = 0;
    int   max_run  = 0;
    logic last_rst = 1'b1;
    logic q[$];
    logic [23:0] code_v = 24'hB53CE1;

    spread dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_readi (o_readi),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

    always #5 i_clk = ~i_clk;

    // Clock edge, then compare valid/data against the scoreboard head.
    task automatic tick();
        logic ev;
        logic ed;
        @(posedge i_clk);
        last_rst = i_reset;
        #1;
        if (last_rst) q.delete();
        ev = (q.size() > 0);
        ed = 1'b0;
        if (ev) ed = q.pop_front();
        if (o_valid === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        checks++;
        assert (o_valid === ev) else begin
            errors++;
            $error("FAIL o_valid observed=%b expected=%b", o_valid, ev);
        end
        checks++;
        assert (o_data === ed) else begin
            errors++;
            $error("FAIL o_data observed=%b expected=%b", o_data, ed);
        end
    endtask

    // Drive one cycle of inputs, check ready, push chips if the bit will be accepted.
    task automatic drive(input logic v, input logic d, input logic rst);
        logic er;
        i_reset = rst;
        i_valid = v;
        i_data  = d;
        #1;
        er = !rst && !last_rst && (q.size() == 0);
        checks++;
        assert (o_readi === er) else begin
            errors++;
            $error("FAIL o_readi observed=%b expected=%b", o_readi, er);
        end
        if (v && er) begin
            for (int k = 0; k < 24; k++) q.push_back(d ^ code_v[23-k]);
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = 1'b0;
        #2;

        // Reset held two clocks, then one-cycle ready latency
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        idle(3);

        // Bit 0 -> code, MSB first
        drive(1'b1, 1'b0, 1'b0);
        idle(26);

        // Bit 1 -> inverted code
        drive(1'b1, 1'b1, 1'b0);
        idle(26);

        // Back-to-back 1 then 0 with i_valid held high
        run_len = 0;
        max_run = 0;
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) drive(1'b1, 1'b0, 1'b0);
        idle(26);
        checks++;
        assert (max_run === 48) else begin
            errors++;
            $error("FAIL gapless_run observed=%0d expected=%0d", max_run, 48);
        end

        // Valid pulse mid-spread is ignored
        drive(1'b1, 1'b0, 1'b0);
        idle(5);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(22);

        // Reset at chip 10 aborts, next bit restarts at chip 0
        drive(1'b1, 1'b0, 1'b0);
        idle(10);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(26);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
